// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulator: FSM state encoding,
// default datapath widths and small state-decode helpers.
package mac_pkg;

    // Default widths: a 16-bit product summed over up to 16 terms needs
    // 20 bits to stay exact (16 * 65025 = 1040400 < 2^20).
    localparam int DEF_PROD_W = 16;
    localparam int DEF_LEN_W  = 4;
    localparam int DEF_SUM_W  = DEF_PROD_W + DEF_LEN_W;

    // Job sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mac_state_e;

    // A job is in flight whenever the sequencer has left IDLE.
    function automatic logic state_is_busy(input mac_state_e s);
        return (s != IDLE);
    endfunction

    // Products are only taken while terms are still being collected.
    function automatic logic state_takes_prod(input mac_state_e s);
        return (s == ACCUM);
    endfunction

    // A finished result is presented only while waiting for the consumer.
    function automatic logic state_has_result(input mac_state_e s);
        return (s == DONE);
    endfunction

endpackage

// File: rtl/mac_accumulator.sv
// Dot-product accumulator: sums a programmed number of unsigned products
// arriving on a valid/ready stream and presents the exact total on a
// valid/ready result port. Single module holding the job FSM, the
// remaining-term down-counter and the accumulator register.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int SUM_W  = PROD_W + LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              prod_ready,
    output logic              sum_valid,
    output logic [SUM_W-1:0]  sum,
    input  logic              sum_ready,
    output logic              busy
);

    // The counter needs one extra bit so that a length field of 0 can
    // stand for the full 2^LEN_W terms.
    localparam int CNT_W = LEN_W + 1;
    localparam int EXT_W = SUM_W - PROD_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    mac_state_e         state_r;
    mac_state_e         state_nxt_s;
    logic [SUM_W-1:0]   acc_r;
    logic [SUM_W-1:0]   acc_nxt_s;
    logic [SUM_W-1:0]   acc_add_s;
    logic [SUM_W-1:0]   sum_r;
    logic [SUM_W-1:0]   sum_nxt_s;
    logic [CNT_W-1:0]   rem_r;
    logic [CNT_W-1:0]   rem_nxt_s;
    logic [CNT_W-1:0]   len_terms_s;
    logic               accept_s;
    logic               last_term_s;
    logic               prod_ready_r;
    logic               sum_valid_r;
    logic               busy_r;

    // prod_ready_r is a registered copy of the ACCUM decode, so a handshake
    // depends only on flops plus the upstream valid.
    assign accept_s    = prod_valid & prod_ready_r;
    assign last_term_s = accept_s & (rem_r == CNT_ONE);
    assign acc_add_s   = acc_r + {{EXT_W{1'b0}}, prod};
    assign len_terms_s = (len == {LEN_W{1'b0}}) ? {1'b1, {LEN_W{1'b0}}}
                                                : {1'b0, len};

    // Next-state selection; abort overrides every other event.
    always_comb begin
        state_nxt_s = state_r;
        if (abort) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_nxt_s = ACCUM;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ACCUM: begin
                    if (last_term_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = ACCUM;
                    end
                end
                DONE: begin
                    if (sum_ready) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Accumulator, remaining-term count and result capture.
    always_comb begin
        acc_nxt_s = acc_r;
        rem_nxt_s = rem_r;
        sum_nxt_s = sum_r;
        if (abort) begin
            acc_nxt_s = {SUM_W{1'b0}};
            rem_nxt_s = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        acc_nxt_s = {SUM_W{1'b0}};
                        rem_nxt_s = len_terms_s;
                    end else begin
                        acc_nxt_s = acc_r;
                        rem_nxt_s = rem_r;
                    end
                end
                ACCUM: begin
                    if (accept_s) begin
                        acc_nxt_s = acc_add_s;
                        rem_nxt_s = rem_r - CNT_ONE;
                    end else begin
                        acc_nxt_s = acc_r;
                        rem_nxt_s = rem_r;
                    end
                    // The result register loads on the final handshake so
                    // the total is visible together with sum_valid.
                    if (last_term_s) begin
                        sum_nxt_s = acc_add_s;
                    end else begin
                        sum_nxt_s = sum_r;
                    end
                end
                DONE: begin
                    acc_nxt_s = acc_r;
                    rem_nxt_s = rem_r;
                end
                default: begin
                    acc_nxt_s = {SUM_W{1'b0}};
                    rem_nxt_s = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r <= {SUM_W{1'b0}};
            rem_r <= {CNT_W{1'b0}};
            sum_r <= {SUM_W{1'b0}};
        end else begin
            acc_r <= acc_nxt_s;
            rem_r <= rem_nxt_s;
            sum_r <= sum_nxt_s;
        end
    end

    // Status outputs registered from the state being entered, so each one
    // always equals a decode of state_r.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_ready_r <= 1'b0;
            sum_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            prod_ready_r <= state_takes_prod(state_nxt_s);
            sum_valid_r  <= state_has_result(state_nxt_s);
            busy_r       <= state_is_busy(state_nxt_s);
        end
    end

    assign prod_ready = prod_ready_r;
    assign sum_valid  = sum_valid_r;
    assign sum        = sum_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: an integer-level job model
// predicts the outputs every cycle, and directed scenarios add literal
// checks on key results.
module tb_mac_accumulator;

    localparam int PROD_W = 16;
    localparam int LEN_W  = 4;
    localparam int SUM_W  = 20;

    logic              clk;
    logic              reset;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              abort;
    logic              prod_valid;
    logic [PROD_W-1:0] prod;
    logic              prod_ready;
    logic              sum_valid;
    logic [SUM_W-1:0]  sum;
    logic              sum_ready;
    logic              busy;

    int n_compared;
    int n_mismatched;

    mac_accumulator #(
        .PROD_W(PROD_W),
        .LEN_W (LEN_W),
        .SUM_W (SUM_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .prod_valid(prod_valid),
        .prod      (prod),
        .prod_ready(prod_ready),
        .sum_valid (sum_valid),
        .sum       (sum),
        .sum_ready (sum_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // phase: 0 = waiting for a job, 1 = collecting terms, 2 = result held
    int m_phase;
    int m_left;
    int m_total;
    int m_sum;
    bit m_sum_known;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase     = 0;
            m_left      = 0;
            m_total     = 0;
            m_sum       = 0;
            m_sum_known = 1'b1;
        end else if (abort) begin
            m_phase     = 0;
            m_left      = 0;
            m_total     = 0;
            m_sum_known = 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase = 1;
                m_left  = (len == 0) ? 16 : int'(len);
                m_total = 0;
            end
        end else if (m_phase == 1) begin
            if (prod_valid) begin
                m_total = m_total + int'(prod);
                m_left  = m_left - 1;
                if (m_left == 0) begin
                    m_phase     = 2;
                    m_sum       = m_total;
                    m_sum_known = 1'b1;
                end
            end
        end else begin
            if (sum_ready) m_phase = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model on the falling edge of every cycle.
    always @(negedge clk) begin
        check("prod_ready", {31'd0, prod_ready}, {31'd0, (m_phase == 1)});
        check("busy",       {31'd0, busy},       {31'd0, (m_phase != 0)});
        check("sum_valid",  {31'd0, sum_valid},  {31'd0, (m_phase == 2)});
        if (m_sum_known) check("sum", {12'd0, sum}, m_sum);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_job(input logic [LEN_W-1:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        len   = 4'd0;
    endtask

    task automatic push(input logic [PROD_W-1:0] p);
        prod_valid = 1'b1;
        prod       = p;
        tick();
        prod_valid = 1'b0;
        prod       = 16'd0;
    endtask

    task automatic drain();
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset      = 1'b1;
        start      = 1'b0;
        len        = 4'd0;
        abort      = 1'b0;
        prod_valid = 1'b0;
        prod       = 16'd0;
        sum_ready  = 1'b0;
        tick();
        tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_sum",  {12'd0, sum},  32'd0);
        reset = 1'b0;
        tick();

        // 1: three back-to-back terms, result one cycle after last handshake
        begin_job(4'd3);
        prod_valid = 1'b1;
        prod = 16'd10; tick();
        prod = 16'd20; tick();
        check("t1_not_yet_valid", {31'd0, sum_valid}, 32'd0);
        prod = 16'd30; tick();
        prod_valid = 1'b0;
        check("t1_valid", {31'd0, sum_valid}, 32'd1);
        check("t1_sum",   {12'd0, sum},       32'd60);
        drain();
        check("t1_idle", {31'd0, busy}, 32'd0);
        check("t1_sum_kept", {12'd0, sum}, 32'd60);

        // 2: len=0 means 16 terms of the largest product, with gaps
        begin_job(4'd0);
        for (int i = 0; i < 16; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                prod_valid = 1'b0;
                prod       = 16'd1234;
                tick();
            end
            push(16'd65025);
        end
        check("t2_valid", {31'd0, sum_valid}, 32'd1);
        check("t2_sum",   {12'd0, sum},       32'd1040400);
        drain();

        // 3: consumer stalls; start during DONE is ignored and not queued
        begin_job(4'd2);
        push(16'd5);
        push(16'd6);
        for (int c = 0; c < 5; c++) begin
            check("t3_held_sum",   {12'd0, sum},       32'd11);
            check("t3_held_valid", {31'd0, sum_valid}, 32'd1);
            start = (c == 2);
            len   = 4'd1;
            tick();
        end
        start = 1'b0;
        drain();
        check("t3_idle", {31'd0, busy}, 32'd0);
        tick();
        check("t3_no_queued_start", {31'd0, busy}, 32'd0);

        // 4: abort after 2 of 4 terms, then a clean one-term job
        begin_job(4'd4);
        push(16'd100);
        push(16'd200);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("t4_aborted", {31'd0, busy}, 32'd0);
        begin_job(4'd1);
        push(16'd7);
        check("t4_sum", {12'd0, sum}, 32'd7);
        drain();

        // 5: asynchronous reset mid-job, then dropped products in IDLE
        begin_job(4'd3);
        push(16'd9);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_ready", {31'd0, prod_ready}, 32'd0);
        check("t5_rst_busy",  {31'd0, busy},       32'd0);
        check("t5_rst_valid", {31'd0, sum_valid},  32'd0);
        check("t5_rst_sum",   {12'd0, sum},        32'd0);
        tick();
        reset = 1'b0;
        prod_valid = 1'b1;
        prod       = 16'd50;
        tick();
        tick();
        tick();
        prod_valid = 1'b0;
        check("t5_still_idle", {31'd0, busy}, 32'd0);
        begin_job(4'd1);
        push(16'd3);
        check("t5_sum_clean", {12'd0, sum}, 32'd3);
        drain();

        // 6: abort collides with the last-term handshake
        begin_job(4'd2);
        push(16'd4);
        prod_valid = 1'b1;
        prod       = 16'd5;
        abort      = 1'b1;
        tick();
        prod_valid = 1'b0;
        abort      = 1'b0;
        check("t6_no_valid", {31'd0, sum_valid}, 32'd0);
        check("t6_idle",     {31'd0, busy},      32'd0);
        tick();
        check("t6_stay_no_valid", {31'd0, sum_valid}, 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 The block SHALL have parameter PROD_W, default 16, meaning the width of each incoming product.
REQ-002 The block SHALL have parameter LEN_W, default 4, meaning the width of the term-count field.
REQ-003 The block SHALL have parameter SUM_W, default PROD_W+LEN_W (20), meaning the width of the accumulator and result.
REQ-004 The block SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: the reset, asynchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: request to begin a new dot-product job.
REQ-007 The block SHALL have port len, input, LEN_W bits: number of terms, sampled with start; 0 encodes 2^LEN_W (16).
REQ-008 The block SHALL have port abort, input, 1 bit: synchronous job cancel.
REQ-009 The block SHALL have port prod_valid, input, 1 bit: a product is present on prod.
REQ-010 The block SHALL have port prod, input, PROD_W bits: unsigned product from the upstream multiplier stage.
REQ-011 The block SHALL have port prod_ready, output, 1 bit: the block accepts prod this cycle.
REQ-012 The block SHALL have port sum_valid, output, 1 bit: sum holds a completed result.
REQ-013 The block SHALL have port sum, output, SUM_W bits: the accumulated result.
REQ-014 The block SHALL have port sum_ready, input, 1 bit: the consumer takes sum this cycle.
REQ-015 The block SHALL have port busy, output, 1 bit: a job is in progress (state not IDLE).

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-017 In IDLE with start=1, the block SHALL latch the term count (len, 0 meaning 16), clear the accumulator to 0 and enter ACCUM on the next edge.
REQ-018 In ACCUM, prod_ready SHALL be 1; outputs SHALL be registered, with prod_ready derived from the state register only.
REQ-019 A product SHALL be accepted only on a cycle where prod_valid=1 and prod_ready=1; on acceptance the accumulator SHALL add prod (zero-extended to SUM_W) and the remaining count SHALL decrement by 1.
REQ-020 prod_valid=0 cycles in ACCUM SHALL leave the accumulator and remaining count unchanged, with no timeout.
REQ-021 On acceptance of the last term, the block SHALL enter DONE on the next edge with sum equal to the full total, i.e. sum_valid rises exactly 1 cycle after the final handshake.
REQ-022 The sum SHALL be exact with no wrap: the maximum value 16*65025=1040400 is less than 2^20.
REQ-023 In DONE, sum_valid SHALL be 1 and sum SHALL be held stable; prod_ready SHALL be 0.
REQ-024 When sum_valid=1 and sum_ready=1, the block SHALL return to IDLE on the next edge with sum_valid=0; sum SHALL retain its last value.
REQ-025 start SHALL be ignored in ACCUM and DONE, and SHALL NOT be queued.
REQ-026 abort=1 in any state SHALL return the block to IDLE on the next edge with sum_valid=0 and the accumulator cleared; abort SHALL have priority over start, handshakes and completion in the same cycle.
REQ-027 prod_ready SHALL be 0 in IDLE; products presented in IDLE SHALL be dropped and SHALL NOT be accumulated.
REQ-028 busy SHALL be 1 in ACCUM and DONE, and 0 in IDLE.

Reset
REQ-029 Asserting reset SHALL immediately force the state to IDLE and set prod_ready=0, sum_valid=0, busy=0, sum=0, the accumulator to 0 and the remaining count to 0.
REQ-030 Reset asserted mid-job SHALL discard the job; after reset deasserts, the block SHALL wait for a fresh start.

Structure
REQ-031 The FSM state enumeration and the default widths (PROD_W=16, LEN_W=4, SUM_W=20) SHALL reside in the shared package mac_pkg.
REQ-032 The block SHALL be a single module with no sub-modules, containing the FSM, the remaining-count down-counter and the accumulator register.

Verification
REQ-033 The bench SHALL cover: start, len=3; products 10, 20, 30 back-to-back; sum_ready=1 -> sum=60, sum_valid high exactly 1 cycle after the third handshake, then IDLE.
REQ-034 The bench SHALL cover: len=0; 16 products of 65025 with random prod_valid gaps -> sum=1040400, no wrap, count unchanged during gaps.
REQ-035 The bench SHALL cover: job complete with sum_ready=0 for 5 cycles, start pulsed during DONE -> sum held constant, start ignored, IDLE only after sum_ready=1.
REQ-036 The bench SHALL cover: abort after 2 of 4 terms, then start, len=1, prod=7 -> sum=7, with no residue from the aborted job.
REQ-037 The bench SHALL cover: reset asserted asynchronously mid-ACCUM -> all outputs 0 immediately, and prod_valid pulses in IDLE are not accumulated.
REQ-038 The bench SHALL cover: abort and the last-term handshake in the same cycle -> IDLE, sum_valid stays 0.
